fc_l2_port_arbiter: RTL and testbench

- Shares one 36-bit TCDM-style L2 master port between NB_REQ requesters, e.g. FC core data bus plus HWPE ports.
- Sits between the FC subsystem's requesters and the L2 interconnect.
- Handles req/gnt arbitration, tracks outstanding transactions, and routes in-order responses (r_valid/r_rdata/r_opc) back to the requester that issued each one.

---
 rtl/fc_l2_port_arbiter_if.sv | 42 ++++
 rtl/fc_l2_port_arbiter.sv | 133 +++++++++++++
 tb/tb_fc_l2_port_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_l2_port_arbiter_if.sv
// Requester-side and L2-side TCDM signals of the FC L2 port arbiter.
// slave: the arbiter's view; master: the requesters and L2 interconnect driving it.
interface fc_l2_port_arbiter_if #(
   parameter int NB_REQ     = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 36,
   parameter int BE_WIDTH   = 4
);
   logic [NB_REQ-1:0]                 s_req_i;
   logic [NB_REQ-1:0][ADDR_WIDTH-1:0] s_add_i;
   logic [NB_REQ-1:0]                 s_wen_i;
   logic [NB_REQ-1:0][DATA_WIDTH-1:0] s_wdata_i;
   logic [NB_REQ-1:0][BE_WIDTH-1:0]   s_be_i;
   logic [NB_REQ-1:0]                 s_gnt_o;
   logic [NB_REQ-1:0]                 s_r_valid_o;
   logic [DATA_WIDTH-1:0]             s_r_rdata_o;
   logic                              s_r_opc_o;

   logic                              m_req_o;
   logic [ADDR_WIDTH-1:0]             m_add_o;
   logic                              m_wen_o;
   logic [DATA_WIDTH-1:0]             m_wdata_o;
   logic [BE_WIDTH-1:0]               m_be_o;
   logic                              m_gnt_i;
   logic                              m_r_valid_i;
   logic [DATA_WIDTH-1:0]             m_r_rdata_i;
   logic                              m_r_opc_i;

   modport slave (
      input  s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
      input  m_gnt_i, m_r_valid_i, m_r_rdata_i, m_r_opc_i,
      output s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_opc_o,
      output m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o
   );

   modport master (
      output s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
      output m_gnt_i, m_r_valid_i, m_r_rdata_i, m_r_opc_i,
      input  s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_opc_o,
      input  m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o
   );
endinterface

// File: rtl/fc_l2_port_arbiter.sv
// Shares one TCDM L2 master port among NB_REQ requesters; in-order response routing via an index FIFO.
// FC_L2_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest) instead of round-robin.
module fc_l2_port_arbiter #(
   parameter int NB_REQ     = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 36,
   parameter int BE_WIDTH   = 4,
   parameter int MAX_OUTST  = 4
)(
   input  logic                         clk_i,
   input  logic                         rst_i,
   fc_l2_port_arbiter_if.slave          bus,
   output logic                         spurious_rsp_o,
   output logic [$clog2(MAX_OUTST):0]   outst_cnt_o
);
   localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
   localparam int PTR_W = $clog2(MAX_OUTST);
   localparam int CNT_W = PTR_W + 1;

   logic [IDX_W-1:0]                  w_arb_idx;
   logic [IDX_W-1:0]                  w_winner;
   logic [IDX_W-1:0]                  w_head;
   logic                              w_full;
   logic                              w_empty;
   logic                              w_m_req;
   logic                              w_hs;
   logic                              w_pop;
   logic [ADDR_WIDTH-1:0]             w_add;
   logic [DATA_WIDTH-1:0]             w_wdata;
   logic [BE_WIDTH-1:0]               w_be;

   logic                              r_lock;
   logic [IDX_W-1:0]                  r_lock_idx;
   logic [MAX_OUTST-1:0][IDX_W-1:0]   r_fifo;
   logic [PTR_W-1:0]                  r_wr_ptr;
   logic [PTR_W-1:0]                  r_rd_ptr;
   logic [CNT_W-1:0]                  r_cnt;
   logic                              r_spurious;

`ifdef FC_L2_ARB_FIXED_PRIO_EN
   always_comb begin
      w_arb_idx = '0;
      for (int k = NB_REQ - 1; k >= 0; k--)
         if (bus.s_req_i[k]) w_arb_idx = IDX_W'(k);
   end
`else
   logic [IDX_W-1:0] r_rr_ptr;

   // Scan from the rr pointer upward, wrapping at NB_REQ (which need not be a power of 2).
   always_comb begin : rr_search
      logic [IDX_W:0] w_sum;
      logic           w_found;
      w_arb_idx = r_rr_ptr;
      w_found   = 1'b0;
      w_sum     = '0;
      for (int k = 0; k < NB_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NB_REQ)) w_sum = w_sum - (IDX_W+1)'(NB_REQ);
         if (!w_found && bus.s_req_i[w_sum[IDX_W-1:0]]) begin
            w_found   = 1'b1;
            w_arb_idx = w_sum[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)     r_rr_ptr <= '0;
      else if (w_hs) r_rr_ptr <= (w_winner == IDX_W'(NB_REQ - 1)) ? '0 : w_winner + 1'b1;
   end
`endif

   assign w_winner = r_lock ? r_lock_idx : w_arb_idx;
   // Full blocks grants even on a same-cycle pop, keeping m_r_valid_i out of the grant path.
   assign w_full   = (r_cnt == CNT_W'(MAX_OUTST));
   assign w_empty  = (r_cnt == '0);
   assign w_m_req  = bus.s_req_i[w_winner] & ~w_full;
   assign w_hs     = w_m_req & bus.m_gnt_i;
   assign w_head   = r_fifo[r_rd_ptr];
   assign w_pop    = bus.m_r_valid_i & ~w_empty;

   assign w_add    = bus.s_add_i[w_winner];
   assign w_wdata  = bus.s_wdata_i[w_winner];
   assign w_be     = bus.s_be_i[w_winner];

   assign bus.m_req_o     = w_m_req;
   assign bus.m_add_o     = w_add;
   assign bus.m_wen_o     = bus.s_wen_i[w_winner];
   assign bus.m_wdata_o   = w_wdata;
   assign bus.m_be_o      = w_be;
   assign bus.s_r_rdata_o = bus.m_r_rdata_i;
   assign bus.s_r_opc_o   = bus.m_r_opc_i;

   for (genvar g = 0; g < NB_REQ; g++) begin : g_lane
      assign bus.s_gnt_o[g]     = w_hs  & (w_winner == IDX_W'(g));
      assign bus.s_r_valid_o[g] = w_pop & (w_head   == IDX_W'(g));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_spurious <= 1'b0;
      end else begin
         // Hold the winner while it waits; release on grant or when it withdraws.
         if (w_hs) begin
            r_lock <= 1'b0;
         end else if (w_m_req) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_winner;
         end else if (!bus.s_req_i[w_winner]) begin
            r_lock <= 1'b0;
         end
         if (w_hs)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_hs, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (bus.m_r_valid_i && w_empty) r_spurious <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_hs) r_fifo[r_wr_ptr] <= w_winner;
   end

   assign spurious_rsp_o = r_spurious;
   assign outst_cnt_o    = r_cnt;
endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Scoreboard bench for fc_l2_port_arbiter: stimulus queues expected grants/responses, a monitor checks them.
module tb_fc_l2_port_arbiter;
   localparam int NB = 2, AW = 32, DW = 36, BW = 4, MO = 4, CW = 3;
   localparam logic [AW-1:0] A0 = 32'h1C000100;
   localparam logic [AW-1:0] A1 = 32'h1C000200;

   typedef struct packed { logic [NB-1:0] vec; logic [AW-1:0] addr; } gnt_t;
   typedef struct packed { logic [NB-1:0] vec; logic [DW-1:0] data; logic opc; } rsp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          spur;
   logic [CW-1:0] cnt;

   always #5 clk = ~clk;

   fc_l2_port_arbiter_if #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

   fc_l2_port_arbiter #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTST(MO)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .bus            (bus),
      .spurious_rsp_o (spur),
      .outst_cnt_o    (cnt)
   );

   gnt_t          exp_gnt_q[$];
   rsp_t          exp_rsp_q[$];
   logic [DW:0]   l2_data_q[$];
   int            n_chk = 0;
   int            n_pass = 0;
   int            cyc = 0;
   bit            auto_rsp = 1'b1;
   int            rsp_lat = 1;
   bit            sch_v[16];
   logic [DW:0]   sch_d[16];
   gnt_t          mg;
   rsp_t          mr;
   int            slot;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [DW-1:0] dflt(input int r);
      return {4'h5, (r == 0) ? A0 : A1};
   endfunction

   task automatic eg(input int r);
      gnt_t g;
      g.vec  = (r == 0) ? 2'b01 : 2'b10;
      g.addr = (r == 0) ? A0 : A1;
      exp_gnt_q.push_back(g);
   endtask

   task automatic er(input int r, input logic [DW-1:0] d, input logic o);
      rsp_t e;
      e.vec  = (r == 0) ? 2'b01 : 2'b10;
      e.data = d;
      e.opc  = o;
      exp_rsp_q.push_back(e);
   endtask

   // Advance one cycle and present whatever the L2 model scheduled for it.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      bus.m_r_valid_i = sch_v[cyc % 16];
      {bus.m_r_opc_i, bus.m_r_rdata_i} = sch_d[cyc % 16];
      sch_v[cyc % 16] = 1'b0;
   endtask

   task automatic drive(input logic [NB-1:0] req, input logic gnt);
      bus.s_req_i = req;
      bus.m_gnt_i = gnt;
   endtask

   task automatic pulse(input logic [DW-1:0] d, input logic o);
      bus.m_r_valid_i = 1'b1;
      bus.m_r_rdata_i = d;
      bus.m_r_opc_i   = o;
   endtask

   // Monitor and L2 model: check every grant/response, schedule responses for accepted requests.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.s_gnt_o != '0) begin
            if (exp_gnt_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexp_gnt: got gnt=%b addr=%h expected none (cycle %0d)", bus.s_gnt_o, bus.m_add_o, cyc);
            end else begin
               mg = exp_gnt_q.pop_front();
               chk("gnt", 64'({bus.s_gnt_o, bus.m_add_o}), 64'(mg));
            end
         end
         if (bus.s_r_valid_o != '0) begin
            if (exp_rsp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexp_rsp: got vld=%b data=%h expected none (cycle %0d)", bus.s_r_valid_o, bus.s_r_rdata_o, cyc);
            end else begin
               mr = exp_rsp_q.pop_front();
               chk("rsp", 64'({bus.s_r_valid_o, bus.s_r_rdata_o, bus.s_r_opc_o}), 64'(mr));
            end
         end
         if (auto_rsp && bus.m_req_o && bus.m_gnt_i) begin
            slot = (cyc + rsp_lat) % 16;
            sch_v[slot] = 1'b1;
            sch_d[slot] = (l2_data_q.size() != 0) ? l2_data_q.pop_front() : {1'b0, 4'h5, bus.m_add_o};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         sch_v[i] = 1'b0;
         sch_d[i] = '0;
      end
      bus.s_req_i     = '0;
      bus.s_add_i[0]  = A0;
      bus.s_add_i[1]  = A1;
      bus.s_wen_i     = '1;
      bus.s_wdata_i   = '0;
      bus.s_be_i      = '1;
      bus.m_gnt_i     = 1'b0;
      bus.m_r_valid_i = 1'b0;
      bus.m_r_rdata_i = '0;
      bus.m_r_opc_i   = 1'b0;

      tick(); tick();
      #1;
      chk("rst_cnt", 64'(cnt), 0);
      chk("rst_spur", 64'(spur), 0);
      chk("rst_mreq", 64'(bus.m_req_o), 0);
      chk("rst_gnt", 64'(bus.s_gnt_o), 0);
      tick();
      rst = 1'b0;

      // Both requesting, grant tied high, 1-cycle responses.
      auto_rsp = 1'b1;
      rsp_lat  = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         drive(2'b11, 1'b1);
`ifdef FC_L2_ARB_FIXED_PRIO_EN
         eg(0); er(0, dflt(0), 1'b0);
`else
         eg(k % 2); er(k % 2, dflt(k % 2), 1'b0);
`endif
         #1;
         chk("t1_cnt_le1", 64'(cnt <= 1), 1);
      end
`ifdef FC_L2_ARB_FIXED_PRIO_EN
      tick();
      drive(2'b10, 1'b1);
      eg(1); er(1, dflt(1), 1'b0);
`endif
      tick(); drive(2'b00, 1'b1);
      tick(); #1;
      chk("t1_cnt_idle", 64'(cnt), 0);

      // Lock on stall: rr pointer moved to 1, requester 0 waits, requester 1 joins.
      tick(); drive(2'b01, 1'b1); eg(0); er(0, dflt(0), 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick(); drive(2'b01, 1'b0); #1;
         chk("t2_add_stall", 64'(bus.m_add_o), 64'(A0));
      end
      tick(); drive(2'b11, 1'b0); #1;
      chk("t2_add_locked", 64'(bus.m_add_o), 64'(A0));
      tick(); drive(2'b11, 1'b1); eg(0); er(0, dflt(0), 1'b0);
`ifdef FC_L2_ARB_FIXED_PRIO_EN
      tick(); drive(2'b10, 1'b1); eg(1); er(1, dflt(1), 1'b0);
`else
      tick(); drive(2'b11, 1'b1); eg(1); er(1, dflt(1), 1'b0);
`endif
      tick(); drive(2'b00, 1'b1);
      tick(); tick();

      // Fill the tracking FIFO with no responses.
      auto_rsp = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick(); drive(2'b01, 1'b1); eg(0);
      end
      tick(); drive(2'b01, 1'b1); #1;
      chk("t3_cnt_full", 64'(cnt), 4);
      chk("t3_mreq_full", 64'(bus.m_req_o), 0);
      tick(); drive(2'b01, 1'b1); pulse(36'h000000111, 1'b0); er(0, 36'h000000111, 1'b0); #1;
      chk("t3_mreq_full_pop", 64'(bus.m_req_o), 0);
      tick(); drive(2'b01, 1'b1); eg(0); #1;
      chk("t3_cnt_after_pop", 64'(cnt), 3);
      chk("t3_mreq_resume", 64'(bus.m_req_o), 1);
      tick(); drive(2'b00, 1'b1); #1;
      chk("t3_cnt_refull", 64'(cnt), 4);
      for (int k = 0; k < 4; k++) begin
         tick(); pulse(36'h000000220 + 36'(k), 1'b0); er(0, 36'h000000220 + 36'(k), 1'b0);
      end
      tick(); #1;
      chk("t3_cnt_drained", 64'(cnt), 0);

      // Interleaved 0,1,1,0 with 2-cycle responses and an error on the third.
      auto_rsp = 1'b1;
      rsp_lat  = 2;
      l2_data_q.push_back({1'b0, 36'h0AA});
      l2_data_q.push_back({1'b0, 36'h0BB});
      l2_data_q.push_back({1'b1, 36'h0CC});
      l2_data_q.push_back({1'b0, 36'h0DD});
      tick(); drive(2'b01, 1'b1); eg(0); er(0, 36'h0AA, 1'b0);
      tick(); drive(2'b10, 1'b1); eg(1); er(1, 36'h0BB, 1'b0);
      tick(); drive(2'b10, 1'b1); eg(1); er(1, 36'h0CC, 1'b1);
      tick(); drive(2'b01, 1'b1); eg(0); er(0, 36'h0DD, 1'b0);
      tick(); drive(2'b00, 1'b1);
      tick(); tick(); tick(); #1;
      chk("t4_cnt_drained", 64'(cnt), 0);

      // Spurious response, sticky flag, then reset.
      auto_rsp = 1'b0;
      tick(); pulse(36'h3, 1'b0); #1;
      chk("t5_no_rvalid", 64'(bus.s_r_valid_o), 0);
      tick(); #1;
      chk("t5_spur_set", 64'(spur), 1);
      chk("t5_cnt_zero", 64'(cnt), 0);
      tick(); #1;
      chk("t5_spur_sticky", 64'(spur), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t5_spur_reset", 64'(spur), 0);
      chk("t5_cnt_reset", 64'(cnt), 0);
      tick(); tick();

      chk("gnt_q_empty", 64'(exp_gnt_q.size()), 0);
      chk("rsp_q_empty", 64'(exp_rsp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
